// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg
// Shared types and constants for the instruction-fetch front end.
//   ADDR_W_DEF / DATA_W_DEF : default address and instruction widths
//   PC_STEP                 : byte distance between sequential fetches
//   fetch_state_t           : fetch controller states
//   fetch_entry_t           : {pc, inst} pair at default widths, for decode-side users
package inst_fetch_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int PC_STEP    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Synchronous FIFO with registered storage; used both as the in-flight PC
// queue and as the fetched-instruction buffer.
//   clk, rst   : clock, async active-low reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop, dout  : read request (ignored when empty) and head data
//   flush      : empties the FIFO, overrides push/pop
//   full, empty, count : occupancy status
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign full  = (r_count == (PW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A push at full is accepted only when the head leaves in the same cycle.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch
// Fetch front end: drives the PC register's next value, issues in-order
// instruction-memory requests, buffers responses with their PCs and hands
// {pc, inst} to decode. Redirects flush the buffer and drop stale responses.
//   clk, rst                          : clock, async active-low reset
//   pc_addr / next_pc                 : PC register interface
//   imem_req_valid/ready/addr         : memory request handshake
//   imem_resp_valid/data              : in-order, non-stallable responses
//   redirect_valid/redirect_pc        : branch/exception redirect
//   if_valid/ready/pc/inst            : decode handshake
//
// state | meaning
// IDLE  | just out of reset, no requests issued
// FETCH | issuing requests while credits allow, responses go to the buffer
// DRAIN | after a redirect, discarding responses to stale requests
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_OUTST  = 2,
    parameter int FIFO_DEPTH = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [ADDR_W-1:0] next_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst
);

    localparam int OW    = $clog2(MAX_OUTST) + 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [OW-1:0]     r_drop_cnt;
    logic              r_resp_err;

    logic [OW-1:0]     w_outst;
    logic [OW-1:0]     w_outst_after;
    logic [CW-1:0]     w_buf_count;
    logic [SUM_W-1:0]  w_credit_used;
    logic              w_credit_ok;
    logic              w_pcq_full;
    logic              w_pcq_empty;
    logic [ADDR_W-1:0] w_pcq_head;
    logic              w_buf_full;
    logic              w_buf_empty;
    entry_t            w_buf_din;
    entry_t            w_buf_dout;
    logic              w_req_fire;
    logic              w_resp_ok;
    logic              w_deq_fire;
    logic              w_buf_push;
    logic              w_buf_pop;

    // The PC queue occupancy is exactly the outstanding-request count.
    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTST)) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (w_req_fire),
        .pop   (w_resp_ok),
        .flush (1'b0),
        .din   (pc_addr),
        .dout  (w_pcq_head),
        .full  (w_pcq_full),
        .empty (w_pcq_empty),
        .count (w_outst)
    );

    fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_resp_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (w_buf_push),
        .pop   (w_buf_pop),
        .flush (redirect_valid),
        .din   (w_buf_din),
        .dout  (w_buf_dout),
        .full  (w_buf_full),
        .empty (w_buf_empty),
        .count (w_buf_count)
    );

    // Every request in flight must already own a buffer slot.
    assign w_credit_used = SUM_W'(w_outst) + SUM_W'(w_buf_count);
    assign w_credit_ok   = (w_credit_used < SUM_W'(FIFO_DEPTH))
                        && (w_outst < OW'(MAX_OUTST))
                        && !w_pcq_full && !w_buf_full;

    assign imem_req_valid = (r_state == FETCH) && w_credit_ok && !redirect_valid;
    assign imem_req_addr  = pc_addr;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is ignored.
    assign w_resp_ok     = imem_resp_valid && !w_pcq_empty;
    assign w_outst_after = w_outst + OW'(w_req_fire) - OW'(w_resp_ok);

    assign w_buf_din.pc   = w_pcq_head;
    assign w_buf_din.inst = imem_resp_data;
    assign w_buf_push     = w_resp_ok && (r_state == FETCH) && !redirect_valid;

    assign if_valid   = !w_buf_empty;
    assign if_pc      = w_buf_dout.pc;
    assign if_inst    = w_buf_dout.inst;
    assign w_deq_fire = if_valid && if_ready;
    assign w_buf_pop  = w_deq_fire && !redirect_valid;

    always_comb begin
        next_pc = pc_addr;
        if (rst) begin
            if (redirect_valid)  next_pc = redirect_pc;
            else if (w_req_fire) next_pc = pc_addr + ADDR_W'(PC_STEP);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: w_next_state = FETCH;
            FETCH: begin
                if (redirect_valid)
                    w_next_state = (w_outst_after != '0) ? DRAIN : FETCH;
            end
            DRAIN: begin
                if (redirect_valid)
                    w_next_state = (w_outst_after != '0) ? DRAIN : FETCH;
                else if (r_drop_cnt == '0)
                    w_next_state = FETCH;
                else if (w_resp_ok && (r_drop_cnt == OW'(1)))
                    w_next_state = FETCH;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_drop_cnt <= '0;
            r_resp_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (redirect_valid)
                r_drop_cnt <= w_outst_after;
            else if ((r_state == DRAIN) && w_resp_ok && (r_drop_cnt != '0))
                r_drop_cnt <= r_drop_cnt - OW'(1);
            if (imem_resp_valid && w_pcq_empty)
                r_resp_err <= 1'b1;
        end
    end

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst) !r_resp_err);

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr;
    logic [31:0] next_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .pc_addr         (pc_addr),
        .next_pc         (next_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_inst         (if_inst)
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct { int due; logic [31:0] data; } mrsp_t;
    typedef struct { logic [31:0] pc; logic rdy; logic [31:0] exp_next; logic exp_valid; } vec_t;

    exp_t  exp_q[$];
    mrsp_t mem_q[$];
    vec_t  vecs[6];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fire   = 0;
    int cyc      = 0;
    int lat      = 1;
    bit follow   = 1'b1;

    logic        s_req_valid, s_req_fire, s_if_valid, s_deq, s_redirect, s_resp;
    logic [31:0] s_addr, s_next_pc, s_if_pc, s_if_inst, s_pc_in;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: sample at negedge, score, advance the PC register and memory model.
    task automatic step();
        exp_t e;
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_fire  = imem_req_valid && imem_req_ready;
        s_addr      = imem_req_addr;
        s_next_pc   = next_pc;
        s_pc_in     = pc_addr;
        s_if_valid  = if_valid;
        s_if_pc     = if_pc;
        s_if_inst   = if_inst;
        s_deq       = if_valid && if_ready;
        s_redirect  = redirect_valid;
        s_resp      = imem_resp_valid;
        if (s_redirect) begin
            exp_q.delete();
        end else if (s_deq) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_deq: got pc %h with no expected entry (cycle %0d)", s_if_pc, cyc);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", s_if_pc, e.pc);
                check("sb_inst", s_if_inst, e.inst);
            end
        end
        if (s_req_fire) begin
            exp_q.push_back('{s_addr, memfn(s_addr)});
            mem_q.push_back('{cyc + lat, memfn(s_addr)});
            n_fire++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (follow) pc_addr = s_next_pc;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q[0].data;
            mem_q.delete(0);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
    endtask

    task automatic wait_if_pc(input string name, input logic [31:0] exp_pc);
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (s_if_valid) seen = 1'b1;
        end
        if (seen) check(name, s_if_pc, exp_pc);
        else begin
            n_checks++;
            $display("FAIL %s: if_valid never rose in 12 cycles, expected pc %h", name, exp_pc);
        end
    endtask

    task automatic quiesce(input int n);
        imem_req_ready = 1'b0;
        if_ready       = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_1000, 1'b1, 32'h0000_1004, 1'b1};
        vecs[1] = '{32'h0000_1000, 1'b0, 32'h0000_1000, 1'b1};
        vecs[2] = '{32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h7FFF_FFFC, 1'b1, 32'h8000_0000, 1'b1};
        vecs[4] = '{32'h0000_0020, 1'b0, 32'h0000_0020, 1'b1};
        vecs[5] = '{32'h0000_0024, 1'b1, 32'h0000_0028, 1'b1};

        rst             = 1'b0;
        pc_addr         = 32'h0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        if_ready        = 1'b0;

        // Reset: nothing issued, next_pc tracks pc_addr.
        step();
        check("rst_req_valid", {31'b0, s_req_valid}, 32'h0);
        check("rst_if_valid", {31'b0, s_if_valid}, 32'h0);
        pc_addr = 32'h0000_0040;
        step();
        check("rst_next_pc", s_next_pc, 32'h0000_0040);
        pc_addr = 32'h0;
        step();

        // Release with decode stalled: IDLE one cycle, then fetch 0,4,8,C and stop.
        rst    = 1'b1;
        n_fire = 0;
        step();
        check("idle_no_req", {31'b0, s_req_valid}, 32'h0);
        step();
        check("first_req_valid", {31'b0, s_req_valid}, 32'h1);
        check("first_req_addr", s_addr, 32'h0);
        check("first_next_pc", s_next_pc, 32'h4);
        step();
        check("lat_not_yet", {31'b0, s_if_valid}, 32'h0);
        step();
        check("lat_if_valid", {31'b0, s_if_valid}, 32'h1);
        check("lat_if_pc", s_if_pc, 32'h0);
        check("lat_if_inst", s_if_inst, memfn(32'h0));
        repeat (8) step();
        check("stall_fires", n_fire, 32'd4);
        check("stall_req_valid", {31'b0, s_req_valid}, 32'h0);
        check("stall_head_pc", s_if_pc, 32'h0);
        if_ready = 1'b1;
        repeat (8) step();

        // Memory not ready: next_pc holds, nothing issued.
        imem_req_ready = 1'b0;
        repeat (2) step();
        n_fire = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("nready_hold", s_next_pc, s_pc_in);
        end
        check("nready_fires", n_fire, 32'd0);
        check("nready_req_valid", {31'b0, s_req_valid}, 32'h1);

        // next_pc rule vectors, including the wrap at the top of the address space.
        follow = 1'b0;
        foreach (vecs[i]) begin
            pc_addr        = vecs[i].pc;
            imem_req_ready = vecs[i].rdy;
            step();
            check("vec_next_pc", s_next_pc, vecs[i].exp_next);
            check("vec_req_valid", {31'b0, s_req_valid}, {31'b0, vecs[i].exp_valid});
            check("vec_req_addr", s_addr, vecs[i].pc);
        end

        // Redirect with two requests in flight (3-cycle memory).
        follow  = 1'b1;
        pc_addr = 32'h0000_0040;
        quiesce(6);
        lat            = 3;
        imem_req_ready = 1'b1;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        check("redir_req_blocked", {31'b0, s_req_valid}, 32'h0);
        check("redir_next_pc", s_next_pc, 32'h0000_0100);
        redirect_valid = 1'b0;
        step();
        check("drain1_resp", {31'b0, s_resp}, 32'h1);
        check("drain1_no_req", {31'b0, s_req_valid}, 32'h0);
        step();
        check("drain2_resp", {31'b0, s_resp}, 32'h1);
        check("drain2_no_req", {31'b0, s_req_valid}, 32'h0);
        step();
        check("post_drain_req", {31'b0, s_req_valid}, 32'h1);
        check("post_drain_addr", s_addr, 32'h0000_0100);
        wait_if_pc("redir_first_pc", 32'h0000_0100);

        // Redirect coincident with a response and a dequeue (2-cycle memory).
        quiesce(6);
        lat            = 2;
        if_ready       = 1'b0;
        imem_req_ready = 1'b1;
        repeat (5) step();
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        check("coinc_resp", {31'b0, s_resp}, 32'h1);
        check("coinc_deq", {31'b0, s_deq}, 32'h1);
        check("coinc_req_blocked", {31'b0, s_req_valid}, 32'h0);
        check("coinc_next_pc", s_next_pc, 32'h0000_0200);
        redirect_valid = 1'b0;
        step();
        check("coinc_flushed", {31'b0, s_if_valid}, 32'h0);
        check("coinc_drain", {31'b0, s_req_valid}, 32'h0);
        step();
        check("coinc_refetch", {31'b0, s_req_valid}, 32'h1);
        check("coinc_refetch_addr", s_addr, 32'h0000_0200);
        wait_if_pc("coinc_first_pc", 32'h0000_0200);

        // Everything issued has been delivered or legitimately dropped.
        quiesce(8);
        check("sb_empty", exp_q.size(), 32'd0);
        check("end_if_valid", {31'b0, s_if_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
